// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: shared mode encoding and default counter width for the pulse stretcher
package pulse_stretch_pkg;
  typedef enum logic {RETRIG = 1'b0, ONESHOT = 1'b1} ps_mode_e;
  localparam int PS_CNT_W = 8;
endpackage

// File: rtl/pulse_stretch_ch.sv
// pulse_stretch_ch: one stretcher channel (trigger qualify, remaining-cycle counter, output, sticky ovr)
// PULSE_STRETCH_EDGE_EN selects rising-edge triggering instead of level triggering
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int CNT_W = PS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pulse,
  input  logic [CNT_W-1:0] leff,
  input  ps_mode_e         mode,
  input  logic             clr_ovr,
  output logic             out_pulse,
  output logic             ovr
);
  logic [CNT_W-1:0] rem;
  ps_mode_e mode_q;
  logic trig, last, accept, drop;
`ifdef PULSE_STRETCH_EDGE_EN
  logic in_q;
  always_ff @(posedge clk) in_q <= rst ? 1'b0 : in_pulse;
  assign trig = in_pulse & ~in_q;
`else
  assign trig = in_pulse;
`endif
  assign last = out_pulse && rem == '0;
  assign accept = trig && (!out_pulse || last || mode_q == RETRIG);
  assign drop = trig && !accept;
  // mode is latched at acceptance so a mid-stretch mode change cannot affect the running pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pulse <= 1'b0;
      rem       <= '0;
      mode_q    <= RETRIG;
      ovr       <= 1'b0;
    end else begin
      out_pulse <= accept | (out_pulse & ~last);
      rem       <= accept ? leff - 1'b1 : (out_pulse && !last) ? rem - 1'b1 : rem;
      mode_q    <= accept ? mode : mode_q;
      ovr       <= drop | (ovr & ~clr_ovr);
    end
  end
endmodule

// File: rtl/pulse_stretcher_mc.sv
// pulse_stretcher_mc: multi-channel runtime-configurable pulse stretcher with lost-event flags
// PULSE_STRETCH_EDGE_EN selects rising-edge triggering instead of level triggering
module pulse_stretcher_mc
  import pulse_stretch_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = PS_CNT_W,
  parameter int DEFAULT_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_pulse,
  input  logic [CNT_W-1:0]    len_cfg,
  input  logic                mode,
  input  logic [CHANNELS-1:0] clr_ovr,
  output logic [CHANNELS-1:0] out_pulse,
  output logic [CHANNELS-1:0] ovr
);
  logic [CNT_W-1:0] leff;
  assign leff = (len_cfg == '0) ? CNT_W'(DEFAULT_LEN) : len_cfg;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pulse_stretch_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .in_pulse (in_pulse[c]),
      .leff     (leff),
      .mode     (ps_mode_e'(mode)),
      .clr_ovr  (clr_ovr[c]),
      .out_pulse(out_pulse[c]),
      .ovr      (ovr[c])
    );
  end
endmodule
